// File: rtl/stop_it_rounds.sv
// stop_it_rounds: multi-round stop-it game controller.
// A round latches a random target, shows it, then counts the game count
// down once per tick until the player presses stop. A hit shifts a one
// into the LED score bar. A miss costs a life. A full score bar means WON
// and no lives left means LOST; both terminal states reset the score and
// the lives.
// Optional build macro STOP_IT_ROUNDS_TOLERANCE_EN: a stop also counts as
// a hit when the count is one above or one below the target (modulo 2^CNT_W).
// Display outputs (digits_o, digit_en_o, leds_o) are registered from the
// next-state values, so they follow state_o with no extra cycle of lag.
module stop_it_rounds #(
  parameter int CNT_W       = 5,
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_W     = 16,
  parameter int LIVES       = 3,
  parameter int SHOW_TICKS  = 8,
  parameter int FLASH_TICKS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick_i,
  input  logic                    go_i,
  input  logic                    stop_i,
  input  logic                    load_i,
  input  logic [CNT_W-1:0]        rand_i,
  input  logic [SCORE_W-1:0]      switches_i,
  output logic [SCORE_W-1:0]      leds_o,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic [2:0]              lives_o,
  output logic [2:0]              state_o
);

  localparam int MAXT = (SHOW_TICKS > FLASH_TICKS) ? SHOW_TICKS : FLASH_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int HD   = NUM_DIGITS / 2;
  localparam int HB   = 2 * NUM_DIGITS;

  localparam logic [TW-1:0] SHOW_END  = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] FLASH_END = TW'(FLASH_TICKS - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  localparam logic [NUM_DIGITS-1:0] EN_ALL = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] EN_LO  = {{HD{1'b0}}, {HD{1'b1}}};
  localparam logic [NUM_DIGITS-1:0] EN_HI  = {{HD{1'b1}}, {HD{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHOW    = 3'd1,
    S_RUN     = 3'd2,
    S_CORRECT = 3'd3,
    S_WRONG   = 3'd4,
    S_WON     = 3'd5,
    S_LOST    = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        target_q, target_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [2:0]              lives_q, lives_d;
  logic [SCORE_W-1:0]      leds_q, leds_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;

  logic hit;
  logic show_end;
  logic flash_end;

  assign show_end  = tick_i && (timer_q == SHOW_END);
  assign flash_end = tick_i && (timer_q == FLASH_END);

`ifdef STOP_IT_ROUNDS_TOLERANCE_EN
  logic [CNT_W-1:0] target_p1;
  logic [CNT_W-1:0] target_m1;
  assign target_p1 = target_q + CNT_W'(1);
  assign target_m1 = target_q - CNT_W'(1);
  // Hit window: target-1 .. target+1, wrapping modulo 2^CNT_W
  assign hit = (count_q == target_q) || (count_q == target_p1) || (count_q == target_m1);
`else
  assign hit = (count_q == target_q);
`endif

  // Next-state logic: FSM transitions and game datapath updates
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    score_d  = score_q;
    lives_d  = lives_q;
    case (state_q)
      S_IDLE: begin
        // stop outranks load, load outranks go; stop itself does nothing here
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (load_i) begin
          score_d = switches_i;
        end else if (go_i) begin
          target_d = rand_i;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (show_end) state_d = S_RUN;
      end
      S_RUN: begin
        // stop wins over a coincident tick: the pre-decrement count is judged
        if (stop_i) begin
          if (hit) begin
            state_d = S_CORRECT;
            score_d = {score_q[SCORE_W-2:0], 1'b1};
          end else begin
            state_d = S_WRONG;
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          end
        end else if (tick_i) begin
          count_d = count_q - CNT_W'(1);
        end
      end
      S_CORRECT: begin
        if (flash_end) state_d = (&score_q) ? S_WON : S_IDLE;
      end
      S_WRONG: begin
        if (flash_end) state_d = (lives_q == 3'd0) ? S_LOST : S_IDLE;
      end
      S_WON, S_LOST: begin
        if (flash_end) begin
          state_d = S_IDLE;
          score_d = '0;
          lives_d = LIVES_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Phase timer restarts on every state entry
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick_i) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Display decode from next-state values
  always_comb begin
    digits_d   = {HB'(target_d), HB'(count_d)};
    digit_en_d = '0;
    leds_d     = score_d;
    case (state_d)
      S_IDLE:    digit_en_d = EN_LO;
      S_SHOW:    digit_en_d = EN_ALL;
      S_RUN:     digit_en_d = EN_ALL;
      S_CORRECT: digit_en_d = timer_d[0] ? EN_ALL : '0;
      S_WRONG:   digit_en_d = timer_d[0] ? EN_LO : EN_HI;
      S_WON: begin
        digit_en_d = timer_d[0] ? EN_ALL : '0;
        leds_d     = timer_d[0] ? {SCORE_W{1'b1}} : '0;
      end
      S_LOST:    digit_en_d = timer_d[0] ? EN_HI : '0;
      default:   digit_en_d = '0;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      count_q    <= {CNT_W{1'b1}};
      target_q   <= '0;
      score_q    <= '0;
      lives_q    <= LIVES_INIT;
      leds_q     <= '0;
      digits_q   <= '0;
      digit_en_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      target_q   <= target_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      leds_q     <= leds_d;
      digits_q   <= digits_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign leds_o     = leds_q;
  assign digits_o   = digits_q;
  assign digit_en_o = digit_en_q;
  assign lives_o    = lives_q;
  assign state_o    = state_q;

endmodule

// File: doc/stop_it_rounds.md
Name: stop_it_rounds

Overview:
- Parametrised successor of the single-round stop-it game FSM.
- Adds configurable widths, tick-based phase lengths, a lives counter, an LED score bar and terminal WON/LOST states.
- Sits between the board wrapper and the seven-segment/LED drivers. Clocked on the system clock, with the slow-rate tick supplied as an enable.
- The random target is supplied externally by the lfsr block.

Parameters:
- CNT_W, 5: width of game counter and target.
- NUM_DIGITS, 4: seven-segment digits driven. Must be even; CNT_W <= 2*NUM_DIGITS.
- SCORE_W, 16: LED score bar width.
- LIVES, 3: wrong guesses allowed before LOST (1..7).
- SHOW_TICKS, 8: ticks spent in SHOW.
- FLASH_TICKS, 16: ticks spent in WRONG/CORRECT/WON/LOST.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- tick_i  in  1  one-cycle game-rate strobe (nominally 4 Hz)
- go_i  in  1  start round (btnC)
- stop_i  in  1  stop counter (btnU)
- load_i  in  1  load score bar from switches
- rand_i  in  CNT_W  random target from lfsr
- switches_i  in  SCORE_W  preload value for score bar
- leds_o  out  SCORE_W  score bar
- digits_o  out  4*NUM_DIGITS  packed nibbles: low half = game count, high half = target, each zero-extended
- digit_en_o  out  NUM_DIGITS  per-digit enable
- lives_o  out  3  remaining lives
- state_o  out  3  encoded state, for debug/verification

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE
  - game count = 2^CNT_W-1
  - target = 0
  - leds_o = 0
  - lives_o = LIVES
  - tick timer = 0
  - digit_en_o = all 0
  - digits_o = 0
- Reset asserted mid-operation overrides everything on the next edge.
- All state changes happen on clk_i edges. Tick-counted actions occur only on cycles where tick_i=1.
- Button inputs are single-cycle pulses, already debounced. Same-cycle priority: rst_i > stop_i > load_i > go_i.
- Tick timer: cleared on every state entry; increments on tick_i. A phase ends on the tick where timer == N-1, so it lasts N ticks.
- IDLE:
  - Low-half digits enabled, showing the game count.
  - load_i sets leds_o = switches_i and stays in IDLE.
  - go_i latches target = rand_i, goes to SHOW.
  - load_i is ignored outside IDLE.
- SHOW:
  - All digits enabled (count and target).
  - After SHOW_TICKS goes to RUN.
  - stop_i in SHOW is ignored.
- RUN:
  - Game count decrements by 1 per tick and wraps 0 -> 2^CNT_W-1.
  - All digits enabled.
  - On stop_i, the count freezes in the same cycle and is compared with target. Match -> CORRECT, else WRONG.
  - If stop_i and tick_i coincide, the pre-decrement value is compared and held.
- CORRECT:
  - On entry, leds_o <= {leds_o[SCORE_W-2:0],1'b1}.
  - All digits flash: enabled when timer[0]=1, disabled when timer[0]=0.
  - After FLASH_TICKS: if leds_o is all ones -> WON, else IDLE.
- WRONG:
  - On entry, lives decrements, saturating at 0.
  - Display alternates halves: low half on odd timer, high half on even timer.
  - After FLASH_TICKS: if lives==0 -> LOST, else IDLE.
- WON:
  - Digits and leds_o flash all-on on odd timer, all-off on even timer. The stored score is kept internally.
  - After FLASH_TICKS goes to IDLE with score = 0 and lives = LIVES.
- LOST:
  - Only the high half flashes.
  - After FLASH_TICKS goes to IDLE with score = 0 and lives = LIVES.
- Game count is not reset between rounds. It holds its value outside RUN.
- Illegal state encodings recover to IDLE on the next cycle.

Optional Feature:
- Macro: STOP_IT_ROUNDS_TOLERANCE_EN.
- Defined: a stop is CORRECT if the count equals target, target+1 or target-1, computed modulo 2^CNT_W (so target 0 also accepts 2^CNT_W-1 and 1).
- Undefined: exact match only. The tolerance logic is absent.

Test Plan:
- Reset, then go_i with rand_i=5 -> state SHOW; after 8 ticks state RUN; count decrements 31, 30, ...; target nibble reads 5.
- In RUN, stop_i when count==5 -> CORRECT. leds_o goes 0x0000 -> 0x0001. Digits toggle every tick for 16 ticks, then IDLE.
- Three stops with count != target -> lives_o 3, 2, 1, 0; after the third WRONG flash, state LOST; after 16 ticks IDLE with lives_o=3 and leds_o=0.
- load_i in IDLE with switches_i=0x7FFF, then one CORRECT round -> leds_o=0xFFFF, then WON flashing for 16 ticks, then IDLE with leds_o=0.
- Simultaneous stop_i+tick_i in RUN with count=0 and target=0 -> CORRECT; count holds 0 (no wrap).
- rst_i asserted in CORRECT mid-flash -> next cycle state IDLE, leds_o=0, lives_o=3, digit_en_o=0.
